// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds the FSM state encodings, funct3 codes and access-size helpers.
package lsu_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ0  = 3'd1;
    localparam logic [2:0] S_WAIT0 = 3'd2;
    localparam logic [2:0] S_REQ1  = 3'd3;
    localparam logic [2:0] S_WAIT1 = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B)  || (f3 == F3_H)  || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Word-addressed data memory port: valid/grant request, rvalid response.
// The load/store unit is the master; the memory is the slave.
interface lsu_if #(
    parameter int XLEN = 32
);

    logic            mem_req;
    logic            mem_gnt;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [3:0]      mem_wstrb;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wstrb,
        output mem_wdata,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wstrb,
        input  mem_wdata,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational alignment: split detect, store strobes/data placement,
// and load data shift plus sign/zero extension over a two-word window.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    output logic        split,
    output logic [7:0]  strb8,
    output logic [63:0] sdata64,
    output logic [31:0] ldata
);

    logic [2:0]  size;
    logic [31:0] wtrunc;
    logic [3:0]  strb4;
    logic [31:0] lword;

    assign size  = size_bytes(funct3[1:0]);
    assign split = ({1'b0, off} + size) > 3'd4;

    always_comb begin
        wtrunc = wdata;
        strb4  = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                wtrunc = {24'b0, wdata[7:0]};
                strb4  = 4'b0001;
            end
            2'b01: begin
                wtrunc = {16'b0, wdata[15:0]};
                strb4  = 4'b0011;
            end
            default: begin
                wtrunc = wdata;
                strb4  = 4'b1111;
            end
        endcase
    end

    assign sdata64 = {32'b0, wtrunc} << {off, 3'b000};
    assign strb8   = {4'b0, strb4} << off;

    // Only the low word of the shifted window is ever needed.
    assign lword = 32'({hi, lo} >> {off, 3'b000});

    always_comb begin
        ldata = lword;
        case (funct3)
            F3_B:    ldata = {{24{lword[7]}}, lword[7:0]};
            F3_H:    ldata = {{16{lword[15]}}, lword[15:0]};
            F3_BU:   ldata = {24'b0, lword[7:0]};
            F3_HU:   ldata = {16'b0, lword[15:0]};
            default: ldata = lword;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: registers one request, issues one or two word
// transactions on the memory port and returns a one-cycle response.
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    lsu_if.master           mem
);

    logic [2:0]      state;
    logic            we_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rd0_q;

    logic [XLEN-1:0] word0;
    logic [XLEN-1:0] word1;
    logic            split;
    logic [7:0]      strb8;
    logic [63:0]     sdata64;
    logic [31:0]     ld_lo;
    logic [31:0]     ld_hi;
    logic [31:0]     ldata;

    assign word0 = {addr_q[XLEN-1:2], 2'b00};
    assign word1 = word0 + XLEN'(4);

    // The second word only exists once the first read has been captured.
    assign ld_lo = (state == S_WAIT1) ? rd0_q : mem.mem_rdata;
    assign ld_hi = (state == S_WAIT1) ? mem.mem_rdata : 32'b0;

    lsu_align u_align (
        .funct3  (f3_q),
        .off     (addr_q[1:0]),
        .wdata   (wdata_q),
        .lo      (ld_lo),
        .hi      (ld_hi),
        .split   (split),
        .strb8   (strb8),
        .sdata64 (sdata64),
        .ldata   (ldata)
    );

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);

    always_comb begin
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wstrb = 4'b0;
        mem.mem_wdata = '0;
        case (state)
            S_REQ0: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = we_q;
                mem.mem_addr  = word0;
                mem.mem_wstrb = we_q ? strb8[3:0] : 4'b0;
                mem.mem_wdata = we_q ? sdata64[31:0] : 32'b0;
            end
            S_REQ1: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = we_q;
                mem.mem_addr  = word1;
                mem.mem_wstrb = we_q ? strb8[7:4] : 4'b0;
                mem.mem_wdata = we_q ? sdata64[63:32] : 32'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            we_q      <= 1'b0;
            f3_q      <= 3'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd0_q     <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        if (f3_legal(req_we, req_funct3)) begin
                            state <= S_REQ0;
                        end else begin
                            state     <= S_RESP;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end
                    end
                end
                S_REQ0: begin
                    if (mem.mem_gnt)
                        state <= S_WAIT0;
                end
                S_WAIT0: begin
                    if (mem.mem_rvalid) begin
                        if (split) begin
                            rd0_q <= mem.mem_rdata;
                            state <= S_REQ1;
                        end else begin
                            state     <= S_RESP;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= we_q ? '0 : ldata;
                        end
                    end
                end
                S_REQ1: begin
                    if (mem.mem_gnt)
                        state <= S_WAIT1;
                end
                S_WAIT1: begin
                    if (mem.mem_rvalid) begin
                        state     <= S_RESP;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= we_q ? '0 : ldata;
                    end
                end
                S_RESP: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a cycle-stepped memory responder inside the
// access task, with hand-computed expected transactions and responses.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    lsu_if #(.XLEN(32)) mif ();

    lsu #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem        (mif)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mem_arr [64];

    int          ntx;
    logic [31:0] tx_addr  [4];
    logic        tx_we    [4];
    logic [3:0]  tx_strb  [4];
    logic [31:0] tx_wdata [4];
    int          lat;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        unstable;
    logic        done;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int gdly);
        int          gcnt;
        logic        rv_due;
        logic [31:0] rv_addr;
        logic        in_req;
        logic [31:0] a0;
        logic [3:0]  s0;
        logic [31:0] d0;
        logic        w0;
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = ~we;
        req_funct3 = 3'b111;
        req_addr   = 32'hFFFF_FFFF;
        req_wdata  = 32'h0;
        ntx = 0; unstable = 0; done = 0; lat = 0;
        gcnt = 0; rv_due = 0; in_req = 0; rv_addr = 0;
        a0 = 0; s0 = 0; d0 = 0; w0 = 0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            mif.mem_gnt    = 1'b0;
            mif.mem_rvalid = 1'b0;
            mif.mem_rdata  = 32'h0BAD_F00D;
            if (rsp_valid) begin
                done    = 1;
                lat     = k;
                r_rdata = rsp_rdata;
                r_err   = rsp_err;
            end else begin
                if (rv_due) begin
                    mif.mem_rvalid = 1'b1;
                    mif.mem_rdata  = mem_arr[rv_addr[7:2]];
                    rv_due = 0;
                end
                if (mif.mem_req) begin
                    if (!in_req) begin
                        in_req = 1;
                        a0 = mif.mem_addr; s0 = mif.mem_wstrb;
                        d0 = mif.mem_wdata; w0 = mif.mem_we;
                    end else if (mif.mem_addr !== a0 || mif.mem_wstrb !== s0 ||
                                 mif.mem_wdata !== d0 || mif.mem_we !== w0) begin
                        unstable = 1;
                    end
                    if (gcnt == gdly) begin
                        mif.mem_gnt = 1'b1;
                        if (ntx < 4) begin
                            tx_addr[ntx]  = mif.mem_addr;
                            tx_we[ntx]    = mif.mem_we;
                            tx_strb[ntx]  = mif.mem_wstrb;
                            tx_wdata[ntx] = mif.mem_wdata;
                        end
                        ntx++;
                        if (mif.mem_we) begin
                            for (int b = 0; b < 4; b++)
                                if (mif.mem_wstrb[b])
                                    mem_arr[mif.mem_addr[7:2]][8*b +: 8] =
                                        mif.mem_wdata[8*b +: 8];
                        end
                        rv_due  = 1;
                        rv_addr = mif.mem_addr;
                        gcnt    = 0;
                        in_req  = 0;
                    end else begin
                        gcnt++;
                    end
                end
            end
        end
        chk("rsp_seen", done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic seen;
        for (int i = 0; i < 64; i++) mem_arr[i] = 32'h0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        mif.mem_gnt = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_mem_req", mif.mem_req, 0);
        chk("rst_mem_we", mif.mem_we, 0);
        chk("rst_mem_addr", mif.mem_addr, 0);
        chk("rst_mem_wstrb", mif.mem_wstrb, 0);
        chk("rst_mem_wdata", mif.mem_wdata, 0);

        mem_arr[4] = 32'hDEAD_BEEF;
        access(1'b0, 3'b010, 32'h10, 32'h0, 0);
        chk("lw_lat", lat, 3);
        chk("lw_rdata", r_rdata, 32'hDEAD_BEEF);
        chk("lw_err", r_err, 0);
        chk("lw_ntx", ntx, 1);
        chk("lw_addr", tx_addr[0], 32'h10);
        chk("lw_we", tx_we[0], 0);

        access(1'b1, 3'b000, 32'h13, 32'h1234_56A5, 0);
        chk("sb_lat", lat, 3);
        chk("sb_ntx", ntx, 1);
        chk("sb_addr", tx_addr[0], 32'h10);
        chk("sb_we", tx_we[0], 1);
        chk("sb_strb", tx_strb[0], 4'b1000);
        chk("sb_wdata", tx_wdata[0], 32'hA500_0000);
        chk("sb_rdata", r_rdata, 0);
        chk("sb_err", r_err, 0);

        mem_arr[8] = 32'h4433_2211;
        mem_arr[9] = 32'h8877_6655;
        access(1'b0, 3'b010, 32'h21, 32'h0, 0);
        chk("lw_split_lat", lat, 5);
        chk("lw_split_ntx", ntx, 2);
        chk("lw_split_a0", tx_addr[0], 32'h20);
        chk("lw_split_a1", tx_addr[1], 32'h24);
        chk("lw_split_rdata", r_rdata, 32'h5544_3322);

        mem_arr[8] = 32'h8000_0000;
        mem_arr[9] = 32'h0000_00FF;
        access(1'b0, 3'b001, 32'h23, 32'h0, 0);
        chk("lh_split_rdata", r_rdata, 32'hFFFF_FF80);
        chk("lh_split_ntx", ntx, 2);
        access(1'b0, 3'b101, 32'h23, 32'h0, 0);
        chk("lhu_split_rdata", r_rdata, 32'h0000_FF80);

        access(1'b1, 3'b010, 32'h42, 32'hAABB_CCDD, 0);
        chk("sw_split_lat", lat, 5);
        chk("sw_split_ntx", ntx, 2);
        chk("sw_split_a0", tx_addr[0], 32'h40);
        chk("sw_split_s0", tx_strb[0], 4'b1100);
        chk("sw_split_d0", tx_wdata[0], 32'hCCDD_0000);
        chk("sw_split_a1", tx_addr[1], 32'h44);
        chk("sw_split_s1", tx_strb[1], 4'b0011);
        chk("sw_split_d1", tx_wdata[1], 32'h0000_AABB);
        chk("sw_split_rdata", r_rdata, 0);

        access(1'b0, 3'b010, 32'h10, 32'h0, 3);
        chk("gnt_wait_lat", lat, 6);
        chk("gnt_wait_stable", unstable, 0);
        chk("gnt_wait_addr", tx_addr[0], 32'h10);
        chk("gnt_wait_rdata", r_rdata, 32'hA5AD_BEEF);
        @(negedge clk);
        chk("hold_rsp_valid", rsp_valid, 0);
        chk("hold_rsp_rdata", rsp_rdata, 32'hA5AD_BEEF);

        access(1'b0, 3'b011, 32'h10, 32'h0, 0);
        chk("illegal_lat", lat, 1);
        chk("illegal_err", r_err, 1);
        chk("illegal_rdata", r_rdata, 0);
        chk("illegal_ntx", ntx, 0);

        mem_arr[63] = 32'h2211_0000;
        mem_arr[0]  = 32'h0000_4433;
        access(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, 0);
        chk("wrap_a0", tx_addr[0], 32'hFFFF_FFFC);
        chk("wrap_a1", tx_addr[1], 32'h0000_0000);
        chk("wrap_rdata", r_rdata, 32'h4433_2211);

        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rstop_mem_req", mif.mem_req, 1);
        mif.mem_gnt = 1'b1;
        @(negedge clk);
        mif.mem_gnt = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mif.mem_rvalid = 1'b1;
        mif.mem_rdata  = 32'h1234_5678;
        chk("rstop_req_ready", req_ready, 1);
        chk("rstop_rsp_valid", rsp_valid, 0);
        chk("rstop_mem_req", mif.mem_req, 0);
        chk("rstop_rsp_rdata", rsp_rdata, 0);
        chk("rstop_rsp_err", rsp_err, 0);
        @(negedge clk);
        mif.mem_rvalid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid) seen = 1'b1;
            @(negedge clk);
        end
        chk("rstop_no_rsp", seen, 0);
        chk("rstop_idle", req_ready, 1);

        access(1'b0, 3'b100, 32'h24, 32'h0, 0);
        chk("lbu_after_rst_lat", lat, 3);
        chk("lbu_after_rst_rdata", r_rdata, 32'h0000_00FF);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit sitting between the datapath's ALU address/rs2 outputs and the data memory. Replaces the direct single-cycle data_mem hookup.
- Accepts one byte/half/word load or store per request and drives a word-addressed valid/grant/rvalid memory port with byte strobes.
- Splits misaligned accesses that cross a word boundary into two word transactions.
- Returns sign/zero-extended load data, or a store completion, as a one-cycle response.

Parameters:
- XLEN, 32, data and byte-address width. Only 32 is supported.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock; synchronous, active-high
- req_valid  in  1  core request valid
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I load/store funct3 encoding
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data (rs2)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors
- rsp_err  out  1  illegal funct3; qualified by rsp_valid
- mem_req  out  1  memory request
- mem_gnt  in  1  memory accepted request this cycle
- mem_we  out  1  write enable
- mem_addr  out  XLEN  word-aligned byte address, bits [1:0] always 0
- mem_wstrb  out  4  byte write strobes
- mem_wdata  out  XLEN  write data
- mem_rvalid  in  1  read data valid / write acknowledge
- mem_rdata  in  XLEN  read data

Behaviour:
- Reset values: req_ready=1 (state IDLE); rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wstrb=0, mem_wdata=0.
- Handshake: request accepted on the cycle req_valid & req_ready. req_ready=1 only in IDLE. Request fields are registered on acceptance; the core may change them afterwards.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
- Illegal access: no memory transaction. IDLE→RESP with rsp_err=1, rdata=0; rsp_valid occurs 1 cycle after acceptance.
- off = addr[1:0]; size = 1/2/4 bytes. split = (off + size > 4).
- FSM: IDLE → REQ0 → WAIT0 → [REQ1 → WAIT1 if split] → RESP → IDLE.
  - REQn: mem_req=1, with addr/we/wstrb/wdata stable until mem_gnt; on mem_gnt go to WAITn.
  - WAITn: mem_req=0; capture mem_rdata on mem_rvalid and go to the next state.
  - RESP: rsp_valid=1 for exactly one cycle.
- Memory protocol: rvalid is returned for both reads and writes, at least 1 cycle after gnt. At most one outstanding transaction.
- Addresses: word0 = {addr[XLEN-1:2], 2'b00}; word1 = word0 + 4, wrapping mod 2^XLEN.
- Stores:
  - sdata64 = zero-extended wdata, truncated to size, shifted left by 8*off.
  - strb8 = ((1<<size)-1) << off.
  - Word0 uses the low 32 bits / low 4 strobes; word1 uses the high halves.
- Loads:
  - Form {rdata1, rdata0} (rdata1 = 0 if not split) and shift right by 8*off.
  - Take the low size bytes; sign-extend for LB/LH, zero-extend for LBU/LHU.
- Latency from acceptance to rsp_valid, with gnt in the first REQ cycle and rvalid the cycle after gnt: 3 cycles unsplit, 5 cycles split. Each cycle of gnt delay adds one cycle.
- mem_gnt outside REQn and mem_rvalid outside WAITn are ignored.
- rsp outputs hold their last value between pulses. Only rsp_valid is a pulse.
- rst mid-operation: next cycle state=IDLE and all outputs at reset values. A late rvalid is ignored and no rsp_valid is produced.
- A new request may be accepted in the cycle after RESP (IDLE).

Decomposition:
- typedefs_pkg gains lsu_state_t (IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP) and the load/store funct3 constants, shared with ctrl_unit/load_extender.
- One sub-module, lsu_align: purely combinational. Computes split, strobes and shifted store data, and performs load shift/extend. The FSM and registers stay in lsu.

Test Plan:
- LW 0x10, mem word 0xDEADBEEF, gnt immediate → one read at mem_addr 0x10; rsp_valid 3 cycles after accept, rsp_rdata=0xDEADBEEF, rsp_err=0.
- SB 0x13, wdata 0x123456A5 → one write at 0x10, wstrb=1000, wdata=0xA5000000; rsp_valid with rdata=0.
- LW 0x21, [0x20]=0x44332211, [0x24]=0x88776655 → reads 0x20 then 0x24; rsp_rdata=0x55443322, latency 5.
- LH 0x23, [0x20]=0x80000000, [0x24]=0x000000FF → rsp_rdata=0xFFFFFF80; repeat as LHU → 0x0000FF80.
- SW 0x42, wdata 0xAABBCCDD → write 0x40 wstrb=1100 wdata=0xCCDD0000, then 0x44 wstrb=0011 wdata=0x0000AABB.
- Fault and illegal cases:
  - Gnt withheld 3 cycles → mem_req/addr stable.
  - rst in WAIT0, rvalid the next cycle → no rsp_valid, req_ready=1.
  - Load funct3=011 → no mem_req; rsp_valid and rsp_err=1 one cycle after accept.
